// File: rtl/riscv_mem_arb_pkg.sv
// Shared types, funct3 codes and alignment helper for the riscv_mem_arbiter slice.
// Optional build macro RISCV_MEM_ARB_RR_EN selects round-robin arbitration.
package riscv_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (funct3[1:0] == 2'b01)      mis = addr_lo[0];
    else if (funct3[1:0] == 2'b10) mis = |addr_lo;
    return mis;
  endfunction

endpackage

// File: rtl/riscv_mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// With RISCV_MEM_ARB_RR_EN defined a tie goes to the port not granted last.
module riscv_mem_arb_pick
  import riscv_mem_arb_pkg::*;
(
  input  logic   i_fetch_req,
  input  logic   i_data_req,
  input  owner_t i_last_owner,
  output logic   o_valid,
  output owner_t o_owner
);

`ifndef RISCV_MEM_ARB_RR_EN
  logic w_unused_last;
  assign w_unused_last = (i_last_owner == OWN_D);
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_valid = i_fetch_req | i_data_req;
    o_owner = OWN_I;
`ifdef RISCV_MEM_ARB_RR_EN
    if (i_fetch_req && i_data_req) begin
      o_owner = (i_last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (i_data_req) begin
      o_owner = OWN_D;
    end
`else
    if (i_data_req) begin
      o_owner = OWN_D;
    end
`endif
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter and sequencer for the single-port data memory.
// Define RISCV_MEM_ARB_RR_EN for round-robin; otherwise data has fixed priority.
module riscv_mem_arbiter
  import riscv_mem_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rsp_valid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic            d_we,
  input  logic [2:0]      d_funct3,
  output logic            d_gnt,
  output logic            d_rsp_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_rsp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_read,
  output logic            mem_write,
  output logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_read_data
);

  state_t          r_state;
  state_t          w_next_state;
  owner_t          r_owner;
  owner_t          w_pick_owner;
  owner_t          w_last_owner;
  logic            w_pick_valid;
  logic            w_accept;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_i_rdata;
  logic [XLEN-1:0] r_d_rdata;
  logic [2:0]      r_funct3;
  logic            r_we;
  logic            r_err;

  riscv_mem_arb_pick u_pick (
    .i_fetch_req  (i_req),
    .i_data_req   (d_req),
    .i_last_owner (w_last_owner),
    .o_valid      (w_pick_valid),
    .o_owner      (w_pick_owner)
  );

  // The memory is busy for the whole ACCESS cycle, so new work is taken only outside it.
  assign w_accept = w_pick_valid && (r_state != ACCESS);

`ifdef RISCV_MEM_ARB_RR_EN
  owner_t r_last_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last_owner <= OWN_I;
    else if (w_accept) r_last_owner <= w_pick_owner;
  end

  assign w_last_owner = r_last_owner;
`else
  assign w_last_owner = OWN_I;
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_pick_valid ? ACCESS : IDLE;
      ACCESS:  w_next_state = RESP;
      RESP:    w_next_state = w_pick_valid ? ACCESS : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    i_gnt       = w_accept && (w_pick_owner == OWN_I);
    d_gnt       = w_accept && (w_pick_owner == OWN_D);
    mem_read    = (r_state == ACCESS) && !r_we && !r_err;
    mem_write   = (r_state == ACCESS) &&  r_we && !r_err;
    i_rsp_valid = (r_state == RESP) && (r_owner == OWN_I);
    d_rsp_valid = (r_state == RESP) && (r_owner == OWN_D);
    d_rsp_err   = (r_state == RESP) && (r_owner == OWN_D) && r_err;
  end

  // Fetches are forced to a plain word load; their alignment is not policed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= OWN_I;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_owner <= w_pick_owner;
      if (w_pick_owner == OWN_D) begin
        r_addr   <= d_addr;
        r_wdata  <= d_wdata;
        r_we     <= d_we;
        r_funct3 <= d_funct3;
        r_err    <= is_misaligned(d_funct3, d_addr[1:0]);
      end else begin
        r_addr   <= i_addr;
        r_wdata  <= '0;
        r_we     <= 1'b0;
        r_funct3 <= LW;
        r_err    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else if (r_state == ACCESS) begin
      if (r_owner == OWN_I) r_i_rdata <= mem_read_data;
      else                  r_d_rdata <= (r_we || r_err) ? '0 : mem_read_data;
    end
  end

  assign mem_addr       = r_addr;
  assign mem_write_data = r_wdata;
  assign mem_funct3     = r_funct3;
  assign i_rdata        = r_i_rdata;
  assign d_rdata        = r_d_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed vector table, corner sequences,
// and a randomized run against a transaction-level model. Honours RISCV_MEM_ARB_RR_EN.
module tb_riscv_mem_arbiter;
  import riscv_mem_arb_pkg::*;

`ifdef RISCV_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rsp_valid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rsp_valid, d_rsp_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_funct3;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_read_data(mem_read_data)
  );

  // Load result shaping by funct3 (sign/zero extension) from the little-endian word at addr.
  function automatic logic [31:0] shape(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'b0, w[7:0]};
      3'b101:  return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Behavioural memory seen by the DUT.
  logic [7:0]  mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [9:0]  ma;
  assign ma = mem_addr[9:0];

  always_comb
    mem_read_data = shape({mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]}, mem_funct3);

  always @(posedge clk) begin
    if (mem_write) begin
      mem[ma] <= mem_write_data[7:0];
      if (mem_funct3[1:0] != 2'b00) mem[ma + 10'd1] <= mem_write_data[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem[ma + 10'd2] <= mem_write_data[23:16];
        mem[ma + 10'd3] <= mem_write_data[31:24];
      end
    end else if (pre_we) begin
      mem[pre_addr]          <= pre_data[7:0];
      mem[pre_addr + 10'd1]  <= pre_data[15:8];
      mem[pre_addr + 10'd2]  <= pre_data[23:16];
      mem[pre_addr + 10'd3]  <= pre_data[31:24];
    end
  end

  // Reference model's own copy of memory contents.
  logic [7:0] ref_mem [0:1023];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [9:0] b;
    b = a[9:0];
    return {ref_mem[b + 10'd3], ref_mem[b + 10'd2], ref_mem[b + 10'd1], ref_mem[b]};
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    pre_we = 1'b1; pre_addr = a[9:0]; pre_data = w;
    for (int k = 0; k < 4; k++) ref_mem[10'(a[9:0] + 10'(k))] = w[8*k +: 8];
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        is_fetch;
    logic [31:0] addr;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic        exp_rd;
    logic        exp_wr;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [16];

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.is_fetch) begin
      i_req = 1'b1; i_addr = v.addr;
    end else begin
      d_req = 1'b1; d_addr = v.addr; d_we = v.we; d_funct3 = v.f3; d_wdata = v.wdata;
    end
    @(negedge clk);
    check({tag, "_gnt"}, {30'b0, i_gnt, d_gnt}, v.is_fetch ? 32'd2 : 32'd1);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check({tag, "_strobes"}, {30'b0, mem_read, mem_write}, {30'b0, v.exp_rd, v.exp_wr});
    check({tag, "_mem_f3"}, {29'b0, mem_funct3}, v.is_fetch ? {29'b0, LW} : {29'b0, v.f3});
    tick();
    @(negedge clk);
    check({tag, "_rsp"}, {29'b0, i_rsp_valid, d_rsp_valid, d_rsp_err},
          v.is_fetch ? 32'd4 : {30'b0, 1'b1, v.exp_err});
    check({tag, "_rdata"}, v.is_fetch ? i_rdata : d_rdata, v.exp_rdata);
    check({tag, "_resp_strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = 1'b0; d_funct3 = '0;

    // Reset state
    #12;
    check("reset_ctrl", {24'b0, i_gnt, d_gnt, i_rsp_valid, d_rsp_valid, d_rsp_err,
                         mem_read, mem_write, 1'b0}, 32'd0);
    check("reset_i_rdata", i_rdata, 32'd0);
    check("reset_d_rdata", d_rdata, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_write_data, 32'd0);
    check("reset_mem_f3", {29'b0, mem_funct3}, 32'd0);
    tick();
    rst = 1'b0;

    for (int k = 0; k < 1024; k += 4) preload(k, $urandom);
    preload(32'h100, 32'hDEADBEEF);
    preload(32'h24,  32'h0);

    //             fetch addr     we  f3   wdata          rd wr er rdata
    vecs[0]  = '{1'b1, 32'h100, 0, LW,  32'h0,        1, 0, 0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h20,  1, SW,  32'h12345678, 0, 1, 0, 32'h0};
    vecs[2]  = '{1'b0, 32'h20,  0, LW,  32'h0,        1, 0, 0, 32'h12345678};
    vecs[3]  = '{1'b0, 32'h21,  0, LH,  32'h0,        0, 0, 1, 32'h0};
    vecs[4]  = '{1'b0, 32'h22,  0, LW,  32'h0,        0, 0, 1, 32'h0};
    vecs[5]  = '{1'b0, 32'h22,  0, LH,  32'h0,        1, 0, 0, 32'h00001234};
    vecs[6]  = '{1'b0, 32'h23,  0, LB,  32'h0,        1, 0, 0, 32'h00000012};
    vecs[7]  = '{1'b0, 32'h24,  1, SB,  32'h000000AB, 0, 1, 0, 32'h0};
    vecs[8]  = '{1'b0, 32'h24,  0, LB,  32'h0,        1, 0, 0, 32'hFFFFFFAB};
    vecs[9]  = '{1'b0, 32'h24,  0, LBU, 32'h0,        1, 0, 0, 32'h000000AB};
    vecs[10] = '{1'b0, 32'h26,  1, SH,  32'h00008001, 0, 1, 0, 32'h0};
    vecs[11] = '{1'b0, 32'h26,  0, LH,  32'h0,        1, 0, 0, 32'hFFFF8001};
    vecs[12] = '{1'b0, 32'h26,  0, LHU, 32'h0,        1, 0, 0, 32'h00008001};
    vecs[13] = '{1'b0, 32'h25,  1, SH,  32'hFFFFFFFF, 0, 0, 1, 32'h0};
    vecs[14] = '{1'b0, 32'h24,  0, LW,  32'h0,        1, 0, 0, 32'h800100AB};
    vecs[15] = '{1'b0, 32'h20,  0, LHU, 32'h0,        1, 0, 0, 32'h00005678};
    for (int v = 0; v < 16; v++) run_vec(v, vecs[v]);

    // Simultaneous requests held for four grants; also exercises back-to-back cadence.
    begin
      int     gcyc [4];
      owner_t gown [4];
      int     ng;
      owner_t exp_own;
      ng = 0;
      do_reset();
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_addr = 32'h20; d_we = 1'b0; d_funct3 = LW;
      for (int c = 0; c < 20 && ng < 4; c++) begin
        @(negedge clk);
        check("arb_one_hot", {30'b0, i_gnt, d_gnt} & 32'd3, (i_gnt && d_gnt) ? 32'd1 : {30'b0, i_gnt, d_gnt});
        if (i_gnt || d_gnt) begin
          gcyc[ng] = c;
          gown[ng] = d_gnt ? OWN_D : OWN_I;
          ng++;
        end
        tick();
      end
      i_req = 1'b0; d_req = 1'b0;
      check("arb_grant_count", ng, 4);
      for (int k = 0; k < ng; k++) begin
        exp_own = (RR && (k % 2 == 1)) ? OWN_I : OWN_D;
        check($sformatf("arb_owner%0d", k), {31'b0, gown[k]}, {31'b0, exp_own});
        check($sformatf("arb_cycle%0d", k), gcyc[k], 2 * k);
      end
      tick();
      tick();
    end

    // Reset asserted during the ACCESS cycle of a store.
    begin
      preload(32'h30, 32'hCAFEF00D);
      d_req = 1'b1; d_addr = 32'h30; d_we = 1'b1; d_funct3 = SW; d_wdata = 32'h11111111;
      @(negedge clk);
      check("rst_store_gnt", {31'b0, d_gnt}, 32'd1);
      tick();
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      check("rst_store_access", {31'b0, mem_write}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rst_async_strobes", {30'b0, mem_read, mem_write}, 32'd0);
      tick();
      check("rst_no_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 32'd0);
      rst = 1'b0;
      i_req = 1'b1; i_addr = 32'h30;
      @(negedge clk);
      check("rst_idle_gnt", {30'b0, i_gnt, d_rsp_valid}, 32'd2);
      tick();
      i_req = 1'b0;
      @(negedge clk);
      check("rst_fetch_read", {30'b0, mem_read, d_rsp_valid}, 32'd2);
      tick();
      @(negedge clk);
      check("rst_fetch_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 32'd2);
      check("rst_store_dropped", i_rdata, 32'hCAFEF00D);
      tick();
    end

    // Randomized traffic against a transaction-level model.
    begin
      logic        fp, dp, dwe;
      logic [31:0] fa, da, dwd;
      logic [2:0]  df3;
      owner_t      model_last, win;
      int          last_g;
      logic        g;
      owner_t      p_own;
      logic        p_we, p_err;
      logic [31:0] p_addr, p_rdata;
      logic [2:0]  loads [5];
      int          nb;
      loads = '{LB, LH, LW, LBU, LHU};
      fp = 1'b0; dp = 1'b0; dwe = 1'b0; fa = '0; da = '0; dwd = '0; df3 = LW;
      p_own = OWN_I; p_we = 1'b0; p_err = 1'b0; p_addr = '0; p_rdata = '0;
      do_reset();
      model_last = OWN_I;
      last_g = -10;
      for (int cyc = 0; cyc < 600; cyc++) begin
        if (!fp && $urandom_range(0, 2) != 0) begin
          fp = 1'b1;
          fa = 32'h200 + ($urandom_range(0, 127) << 2);
        end
        if (!dp && $urandom_range(0, 2) != 0) begin
          dp  = 1'b1;
          dwe = ($urandom_range(0, 2) == 0);
          df3 = dwe ? 3'($urandom_range(0, 2)) : loads[$urandom_range(0, 4)];
          da  = 32'h200 + $urandom_range(0, 511);
          dwd = $urandom;
        end
        i_req = fp; i_addr = fa;
        d_req = dp; d_addr = da; d_we = dwe; d_funct3 = df3; d_wdata = dwd;
        @(negedge clk);

        g = (cyc - last_g >= 2) && (fp || dp);
        if (fp && dp) win = RR ? ((model_last == OWN_I) ? OWN_D : OWN_I) : OWN_D;
        else          win = dp ? OWN_D : OWN_I;
        check("rand_gnt", {30'b0, i_gnt, d_gnt},
              {30'b0, g && (win == OWN_I), g && (win == OWN_D)});

        if (cyc == last_g + 1) begin
          check("rand_strobes", {30'b0, mem_read, mem_write}, {30'b0, !p_we && !p_err, p_we && !p_err});
          check("rand_mem_addr", mem_addr, p_addr);
        end else begin
          check("rand_idle_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        end

        if (cyc == last_g + 2) begin
          check("rand_rsp", {29'b0, i_rsp_valid, d_rsp_valid, d_rsp_err},
                {29'b0, p_own == OWN_I, p_own == OWN_D, p_err});
          check("rand_rdata", (p_own == OWN_I) ? i_rdata : d_rdata, p_rdata);
        end else begin
          check("rand_no_rsp", {30'b0, i_rsp_valid, d_rsp_valid}, 32'd0);
        end

        if (g) begin
          last_g     = cyc;
          model_last = win;
          p_own      = win;
          if (win == OWN_I) begin
            p_we = 1'b0; p_err = 1'b0; p_addr = fa;
            p_rdata = ref_word(fa);
            fp = 1'b0;
          end else begin
            p_we   = dwe;
            p_addr = da;
            p_err  = ((df3[1:0] == 2'b01) && da[0]) || ((df3[1:0] == 2'b10) && (da[1:0] != 2'b00));
            p_rdata = (dwe || p_err) ? 32'd0 : shape(ref_word(da), df3);
            if (dwe && !p_err) begin
              nb = (df3[1:0] == 2'b00) ? 1 : (df3[1:0] == 2'b01) ? 2 : 4;
              for (int k = 0; k < nb; k++) ref_mem[10'(da[9:0] + 10'(k))] = dwd[8*k +: 8];
            end
            dp = 1'b0;
          end
        end
        tick();
      end
      i_req = 1'b0; d_req = 1'b0;
      tick();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-requester arbiter and sequencer sitting in front of the single-port `riscv_memory` data store in the RISC-V core. It shares the memory between the instruction-fetch port (read-only, word) and the load/store port (byte/half/word via funct3). It accepts one request at a time, drives the memory strobes for exactly one access cycle, and returns registered read data with a one-cycle response pulse. Misaligned data accesses are rejected with an error response.

## Interface
- `XLEN`, 32, data and address width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `i_req`  in  1  fetch request; held until `i_gnt`.
- `i_addr`  in  XLEN  fetch address.
- `i_gnt`  out  1  fetch accepted this cycle (combinational).
- `i_rsp_valid`  out  1  fetch response pulse.
- `i_rdata`  out  XLEN  fetch data, valid with `i_rsp_valid`.
- `d_req`  in  1  load/store request; held until `d_gnt`.
- `d_addr`  in  XLEN  data address.
- `d_wdata`  in  XLEN  store data.
- `d_we`  in  1  1 = store, 0 = load.
- `d_funct3`  in  3  RISC-V funct3 width/sign code.
- `d_gnt`  out  1  data request accepted this cycle (combinational).
- `d_rsp_valid`  out  1  data response pulse (loads and stores).
- `d_rdata`  out  XLEN  load data; 0 for stores and errors.
- `d_rsp_err`  out  1  misaligned access, qualified by `d_rsp_valid`.
- `mem_addr`  out  XLEN  memory address.
- `mem_write_data`  out  XLEN  memory write data.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem_funct3`  out  3  memory width/sign code.
- `mem_read_data`  in  XLEN  memory combinational read data.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset → IDLE.
- Acceptance is allowed in IDLE or RESP: if any request is pending, assert the winner's gnt, latch its addr/wdata/we/funct3/owner, and go to ACCESS; otherwise go to or stay in IDLE.
- ACCESS: drive `mem_*` from the latched request. Assert `mem_read` for loads/fetches and `mem_write` for stores. Capture `mem_read_data` into the owner's rdata register. Go to RESP.
- RESP: pulse the owner's rsp_valid for one cycle.
- Fetch is always issued with funct3 = LW (3'b010) and we = 0.
- Default priority is fixed: data beats fetch on a simultaneous request.
- Misaligned access:
  - Conditions: funct3[1:0] = 2'b01 with addr[0] ≠ 0, or funct3[1:0] = 2'b10 with addr[1:0] ≠ 0.
  - In ACCESS, both strobes stay 0.
  - In RESP, `d_rsp_err` = 1 and `d_rdata` = 0.
  - Fetch misalignment is not checked.
- Store response: `d_rsp_valid` = 1 and `d_rdata` = 0.
- rdata registers hold their value until the next response to the same port.
- Reset mid-operation: the FSM returns to IDLE immediately; strobes drop asynchronously; any in-flight access is discarded with no response. Requesters must reissue.

## Timing
- Request visible in cycle N with FSM in IDLE → gnt in N, memory access in N+1, rsp_valid in N+2.
- Peak throughput is one access per 2 cycles, because acceptance in RESP overlaps the response.
- `mem_read` and `mem_write` are never both 1, and are 1 only in ACCESS.
- Reset values:
  - All gnt, rsp_valid, `d_rsp_err`, `mem_read` and `mem_write` are 0.
  - `i_rdata`, `d_rdata`, `mem_addr`, `mem_write_data` and `mem_funct3` are 0.
- gnt is never asserted in ACCESS. A req held during ACCESS is accepted in the following RESP cycle.

## Configuration
- `RISCV_MEM_ARB_RR_EN`:
  - Defined: round-robin. A 1-bit last-owner register, reset to "fetch", gives a simultaneous request to the port not granted last. It updates on every grant.
  - Undefined: fixed data-over-fetch priority; no pointer register.

## Structure
- Package `riscv_mem_arb_pkg` holds:
  - State enum (IDLE/ACCESS/RESP).
  - Owner enum (OWN_I/OWN_D).
  - funct3 constants: LB/LH/LW/LBU/LHU/SB/SH/SW.
  - Misalignment check function.
- Sub-module `riscv_mem_arb_pick`: combinational winner selection from `i_req`, `d_req` and the last-owner input. The last-owner input is ignored when `RISCV_MEM_ARB_RR_EN` is undefined.

## Test plan
- Fetch alone, `i_addr` = 0x100 with mem[0x100..0x103] = 0xDEADBEEF → `i_gnt` at N, `mem_read` at N+1, `i_rsp_valid` and `i_rdata` = 0xDEADBEEF at N+2.
- Store SW `d_addr` = 0x20, `d_wdata` = 0x12345678, then LW from 0x20 → `mem_write` for one cycle only, then `d_rdata` = 0x12345678. Responses arrive at N+2 and N+4.
- Simultaneous `i_req`/`d_req` for 4 consecutive grants:
  - Fixed mode: data granted every time while `d_req` is held.
  - RR mode: order is D, I, D, I.
- LH at 0x21 and LW at 0x22 → both strobes stay 0; `d_rsp_err` = 1 and `d_rdata` = 0 at N+2. LH at 0x22 → err = 0.
- Assert `rst` during ACCESS of a store → `mem_write` drops without waiting for a clock, no rsp_valid is produced, and the FSM is in IDLE after release.
- Back-to-back requests held continuously → grants at N, N+2, N+4 and gnt never in ACCESS.
